// File: rtl/tail_light_sequencer.sv
// Rear-lamp controller: sequenced left/right side groups plus a centre group,
// driven by level turn/brake/hazard requests and self-terminating comfort blinks.
module tail_light_sequencer #(
  parameter int SIDE_LAMPS     = 3,
  parameter int CENTER_LAMPS   = 4,
  parameter int TICK_DIV       = 12_500_000,
  parameter int FILL_MODE      = 0,
  parameter int COMFORT_SWEEPS = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  left_req,
  input  logic                                  right_req,
  input  logic                                  brake,
  input  logic                                  hazard,
  input  logic                                  comfort_l,
  input  logic                                  comfort_r,
  output logic [2*SIDE_LAMPS+CENTER_LAMPS-1:0] leds,
  output logic                                  busy
);

  localparam int L  = 2*SIDE_LAMPS + CENTER_LAMPS;
  localparam int PW = $clog2(SIDE_LAMPS + 1);
  localparam int CW = $clog2(TICK_DIV);
  localparam int NW = $clog2(COMFORT_SWEEPS + 1);

  localparam logic [PW-1:0] POS_LAST  = (FILL_MODE != 0) ? PW'(SIDE_LAMPS) : PW'(SIDE_LAMPS - 1);
  localparam logic [PW-1:0] POS_BLANK = PW'(SIDE_LAMPS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [NW-1:0] COMF_LAST = NW'(COMFORT_SWEEPS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] TURN_L = 3'd1;
  localparam logic [2:0] TURN_R = 3'd2;
  localparam logic [2:0] COMF_L = 3'd3;
  localparam logic [2:0] COMF_R = 3'd4;
  localparam logic [2:0] HAZ    = 3'd5;

  logic [2:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [PW-1:0] pos_reg, pos_next;
  logic [NW-1:0] comf_cnt_reg, comf_cnt_next;
  logic          phase_reg, phase_next;
  logic [L-1:0]  leds_next;
  logic [SIDE_LAMPS-1:0] lamp_on;

  logic step, in_comf, sweep_wrap, comf_done, comf_start, clear;
  logic haz_next, seq_left, seq_right;

  always_comb begin
    step       = (cnt_reg == CNT_LAST);
    in_comf    = (state_reg == COMF_L) || (state_reg == COMF_R);
    sweep_wrap = step && (pos_reg == POS_LAST);
    comf_done  = in_comf && sweep_wrap && (comf_cnt_reg == COMF_LAST);

    // Level requests first, then comfort pulses (left wins), then comfort hold.
    comf_start = 1'b0;
    state_next = IDLE;
    if (hazard || (left_req && right_req)) begin
      state_next = HAZ;
    end else if (left_req) begin
      state_next = TURN_L;
    end else if (right_req) begin
      state_next = TURN_R;
    end else if (comfort_l) begin
      state_next = COMF_L;
      comf_start = 1'b1;
    end else if (comfort_r) begin
      state_next = COMF_R;
      comf_start = 1'b1;
    end else if (in_comf && !comf_done) begin
      state_next = state_reg;
    end

    clear = (state_next != state_reg) || comf_start || (state_next == IDLE);

    if (clear) begin
      cnt_next      = '0;
      pos_next      = '0;
      comf_cnt_next = '0;
      phase_next    = (state_next == HAZ);
    end else begin
      cnt_next      = step ? '0 : cnt_reg + 1'b1;
      pos_next      = step ? ((pos_reg == POS_LAST) ? '0 : pos_reg + 1'b1) : pos_reg;
      comf_cnt_next = (in_comf && sweep_wrap) ? comf_cnt_reg + 1'b1 : comf_cnt_reg;
      phase_next    = (state_reg == HAZ && step) ? ~phase_reg : phase_reg;
    end

    haz_next  = (state_next == HAZ);
    seq_left  = (state_next == TURN_L) || (state_next == COMF_L);
    seq_right = (state_next == TURN_R) || (state_next == COMF_R);
  end

  // Lamp index gi counts outward from the inner edge of a side group.
  genvar gi;
  generate
    for (gi = 0; gi < SIDE_LAMPS; gi++) begin : g_side
      localparam logic [PW-1:0] IDX = PW'(gi);
      if (FILL_MODE != 0) begin : g_fill
        assign lamp_on[gi] = (pos_next >= IDX) && (pos_next != POS_BLANK);
      end else begin : g_dot
        assign lamp_on[gi] = (pos_next == IDX);
      end
      assign leds_next[L-SIDE_LAMPS+gi] = haz_next ? phase_next : (seq_left  ? lamp_on[gi] : brake);
      assign leds_next[SIDE_LAMPS-1-gi] = haz_next ? phase_next : (seq_right ? lamp_on[gi] : brake);
    end
    for (gi = 0; gi < CENTER_LAMPS; gi++) begin : g_center
      assign leds_next[SIDE_LAMPS+gi] = haz_next ? phase_next : brake;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      pos_reg      <= '0;
      comf_cnt_reg <= '0;
      phase_reg    <= 1'b0;
      leds         <= '0;
      busy         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      pos_reg      <= pos_next;
      comf_cnt_reg <= comf_cnt_next;
      phase_reg    <= phase_next;
      leds         <= leds_next;
      busy         <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Directed bench: a dot-mode and a fill-mode instance share stimulus; each
// scenario task checks hand-computed lamp patterns clock by clock.
module tb_tail_light_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic left_req = 1'b0, right_req = 1'b0, brake = 1'b0, hazard = 1'b0;
  logic comfort_l = 1'b0, comfort_r = 1'b0;
  logic [9:0] leds_dot, leds_fill;
  logic       busy_dot, busy_fill;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  tail_light_sequencer #(
    .SIDE_LAMPS(3), .CENTER_LAMPS(4), .TICK_DIV(4), .FILL_MODE(0), .COMFORT_SWEEPS(3)
  ) dut_dot (
    .clk(clk), .rst(rst), .left_req(left_req), .right_req(right_req), .brake(brake),
    .hazard(hazard), .comfort_l(comfort_l), .comfort_r(comfort_r),
    .leds(leds_dot), .busy(busy_dot)
  );

  tail_light_sequencer #(
    .SIDE_LAMPS(3), .CENTER_LAMPS(4), .TICK_DIV(4), .FILL_MODE(1), .COMFORT_SWEEPS(3)
  ) dut_fill (
    .clk(clk), .rst(rst), .left_req(left_req), .right_req(right_req), .brake(brake),
    .hazard(hazard), .comfort_l(comfort_l), .comfort_r(comfort_r),
    .leds(leds_fill), .busy(busy_fill)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (leds_dot !== 10'b0 || busy_dot !== 1'b0 || leds_fill !== 10'b0 || busy_fill !== 1'b0)
      $display("FAIL reset: leds_dot=%b busy_dot=%b leds_fill=%b busy_fill=%b, want all 0",
               leds_dot, busy_dot, leds_fill, busy_fill);
    else passes++;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (leds_dot !== 10'b0 || busy_dot !== 1'b0)
      $display("FAIL idle_after_reset: leds=%b busy=%b, want 0/0", leds_dot, busy_dot);
    else passes++;
    $display("reset: done");
  endtask

  task automatic test_dot_right();
    logic [2:0] pat;
    logic [2:0] base;
    base = 3'b100;
    right_req = 1'b1;
    tick();
    for (int k = 0; k <= 12; k++) begin
      pat = base >> ((k / 4) % 3);
      checks++;
      if (leds_dot !== {7'b0, pat} || busy_dot !== 1'b1)
        $display("FAIL dot_right k=%0d: leds=%b busy=%b, want %b busy=1", k, leds_dot, busy_dot, {7'b0, pat});
      else passes++;
      tick();
    end
    right_req = 1'b0;
    tick();
    tick();
    checks++;
    if (leds_dot !== 10'b0 || busy_dot !== 1'b0)
      $display("FAIL dot_right_release: leds=%b busy=%b, want 0/0", leds_dot, busy_dot);
    else passes++;
    $display("dot_right: done");
  endtask

  task automatic test_fill_left_brake();
    logic [2:0] fill_tab [4];
    logic [2:0] dot_tab [3];
    fill_tab = '{3'b001, 3'b011, 3'b111, 3'b000};
    dot_tab  = '{3'b001, 3'b010, 3'b100};
    left_req = 1'b1;
    brake    = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (leds_fill !== {fill_tab[(k/4)%4], 4'b1111, 3'b111})
        $display("FAIL fill_left k=%0d: leds=%b, want %b", k, leds_fill, {fill_tab[(k/4)%4], 4'b1111, 3'b111});
      else passes++;
      checks++;
      if (leds_dot !== {dot_tab[(k/4)%3], 4'b1111, 3'b111})
        $display("FAIL dot_left_brake k=%0d: leds=%b, want %b", k, leds_dot, {dot_tab[(k/4)%3], 4'b1111, 3'b111});
      else passes++;
      tick();
    end
    left_req = 1'b0;
    tick();
    checks++;
    if (leds_fill !== 10'b1111111111 || busy_fill !== 1'b0)
      $display("FAIL brake_only: leds=%b busy=%b, want 1111111111/0", leds_fill, busy_fill);
    else passes++;
    brake = 1'b0;
    tick();
    checks++;
    if (leds_fill !== 10'b0)
      $display("FAIL brake_release: leds=%b, want 0", leds_fill);
    else passes++;
    $display("fill_left_brake: done");
  endtask

  task automatic test_hazard_mid_sweep();
    logic [9:0] want;
    left_req = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    hazard = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      want = ((k / 4) % 2 == 0) ? 10'b1111111111 : 10'b0;
      checks++;
      if (leds_dot !== want || leds_fill !== want || busy_dot !== 1'b1)
        $display("FAIL hazard k=%0d: dot=%b fill=%b busy=%b, want %b busy=1", k, leds_dot, leds_fill, busy_dot, want);
      else passes++;
      brake = ~brake;
      tick();
    end
    hazard   = 1'b0;
    left_req = 1'b0;
    brake    = 1'b0;
    tick();
    checks++;
    if (leds_dot !== 10'b0 || busy_dot !== 1'b0)
      $display("FAIL hazard_release: leds=%b busy=%b, want 0/0", leds_dot, busy_dot);
    else passes++;
    $display("hazard_mid_sweep: done");
  endtask

  task automatic test_both_turn();
    left_req  = 1'b1;
    right_req = 1'b1;
    tick();
    checks++;
    if (leds_dot !== 10'b1111111111 || busy_dot !== 1'b1)
      $display("FAIL both_turn: leds=%b busy=%b, want 1111111111/1", leds_dot, busy_dot);
    else passes++;
    tick();
    left_req  = 1'b0;
    right_req = 1'b0;
    tick();
    checks++;
    if (leds_dot !== 10'b0 || busy_dot !== 1'b0)
      $display("FAIL both_release: leds=%b busy=%b, want 0/0", leds_dot, busy_dot);
    else passes++;
    $display("both_turn: done");
  endtask

  task automatic test_comfort_right();
    logic [2:0] fill_tab [4];
    logic [2:0] base;
    logic [2:0] dpat;
    fill_tab = '{3'b100, 3'b110, 3'b111, 3'b000};
    base = 3'b100;
    comfort_r = 1'b1;
    tick();
    comfort_r = 1'b0;
    for (int k = 0; k <= 48; k++) begin
      dpat = (k < 36) ? (base >> ((k / 4) % 3)) : 3'b000;
      checks++;
      if (leds_dot !== {7'b0, dpat} || busy_dot !== (k < 36))
        $display("FAIL comfort_dot k=%0d: leds=%b busy=%b, want %b busy=%0d", k, leds_dot, busy_dot, {7'b0, dpat}, (k < 36));
      else passes++;
      checks++;
      if (k < 48) begin
        if (leds_fill !== {7'b0, fill_tab[(k/4)%4]} || busy_fill !== 1'b1)
          $display("FAIL comfort_fill k=%0d: leds=%b busy=%b, want %b busy=1", k, leds_fill, busy_fill, {7'b0, fill_tab[(k/4)%4]});
        else passes++;
      end else begin
        if (leds_fill !== 10'b0 || busy_fill !== 1'b0)
          $display("FAIL comfort_fill_end: leds=%b busy=%b, want 0/0", leds_fill, busy_fill);
        else passes++;
      end
      tick();
    end
    $display("comfort_right: done");
  endtask

  task automatic test_comfort_abort();
    comfort_r = 1'b1;
    tick();
    comfort_r = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    left_req = 1'b1;
    tick();
    checks++;
    if (leds_dot !== 10'b0010000000 || busy_dot !== 1'b1)
      $display("FAIL comfort_abort: leds=%b busy=%b, want 0010000000/1", leds_dot, busy_dot);
    else passes++;
    left_req = 1'b0;
    tick();
    checks++;
    if (leds_dot !== 10'b0 || busy_dot !== 1'b0)
      $display("FAIL comfort_abort_release: leds=%b busy=%b, want 0/0", leds_dot, busy_dot);
    else passes++;
    $display("comfort_abort: done");
  endtask

  task automatic test_back_to_back_comfort();
    comfort_l = 1'b1;
    comfort_r = 1'b1;
    tick();
    comfort_l = 1'b0;
    comfort_r = 1'b0;
    checks++;
    if (leds_dot !== 10'b0010000000)
      $display("FAIL comfort_left_wins: leds=%b, want 0010000000", leds_dot);
    else passes++;
    for (int k = 0; k < 5; k++) tick();
    comfort_r = 1'b1;
    tick();
    comfort_r = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (leds_dot !== ((k < 4) ? 10'b0000000100 : 10'b0000000010))
        $display("FAIL comfort_restart k=%0d: leds=%b", k, leds_dot);
      else passes++;
      tick();
    end
    $display("back_to_back_comfort: done");
  endtask

  task automatic test_async_reset();
    comfort_l = 1'b1;
    tick();
    comfort_l = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (leds_dot !== 10'b0 || busy_dot !== 1'b0 || leds_fill !== 10'b0 || busy_fill !== 1'b0)
      $display("FAIL async_reset: dot=%b/%b fill=%b/%b, want 0", leds_dot, busy_dot, leds_fill, busy_fill);
    else passes++;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (leds_dot !== 10'b0 || busy_dot !== 1'b0)
        $display("FAIL after_reset k=%0d: leds=%b busy=%b, want 0/0", k, leds_dot, busy_dot);
      else passes++;
    end
    right_req = 1'b1;
    tick();
    checks++;
    if (leds_dot !== 10'b0000000100)
      $display("FAIL resume_after_reset: leds=%b, want 0000000100", leds_dot);
    else passes++;
    right_req = 1'b0;
    tick();
    $display("async_reset: done");
  endtask

  initial begin
    test_reset();
    test_dot_right();
    test_fill_left_brake();
    test_hazard_mid_sweep();
    test_both_turn();
    test_comfort_right();
    test_comfort_abort();
    test_back_to_back_comfort();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tail_light_sequencer.md
# tail_light_sequencer

Parametrised rear-lamp controller: the next generation of the fixed 10-LED turn/brake/hazard processor. It drives two sequenced side groups and a centre group from level-sensitive driver requests. It adds an internal step prescaler, selectable dot/fill sweep, and a counted "comfort" lane-change blink that finishes on its own. It sits between the debounced switch inputs and the LED output pins.

## Interface
- SIDE_LAMPS, 3: lamps per side group (≥2)
- CENTER_LAMPS, 4: centre lamps (≥0; 0 = no centre group)
- TICK_DIV, 12_500_000: clk cycles per step tick (≥2)
- FILL_MODE, 0: 0 = walking dot, 1 = cumulative fill
- COMFORT_SWEEPS, 3: full sweeps per comfort request (≥1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- left_req  in  1  left turn, level
- right_req  in  1  right turn, level
- brake  in  1  brake, level
- hazard  in  1  hazard, level
- comfort_l  in  1  one-clk pulse: start left comfort blink
- comfort_r  in  1  one-clk pulse: start right comfort blink
- leds  out  L=2*SIDE_LAMPS+CENTER_LAMPS  lamp drive. leds[L-1:L-SIDE_LAMPS] = left group, outermost at MSB. leds[SIDE_LAMPS-1:0] = right group, outermost at bit 0. Centre group in between.
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, TURN_L, TURN_R, COMF_L, COMF_R, HAZ.
- Next-state priority, evaluated every clk:
  - hazard, or left_req && right_req → HAZ
  - else left_req → TURN_L; else right_req → TURN_R
  - else comfort_l → COMF_L; else comfort_r → COMF_R
  - else a COMF state holds until its sweeps complete
  - else IDLE
- A comfort pulse arriving while a turn or HAZ is active is dropped, not queued.
- A new comfort pulse in an active COMF state restarts that state (same or opposite side).
- Level requests override comfort. Releasing a request returns to IDLE on the next clk.
- Prescaler: counts 0..TICK_DIV-1. step = (cnt == TICK_DIV-1). Cleared to 0 on every FSM state change or restart.
- Sweep position pos, width $clog2(SIDE_LAMPS+1), cleared on state change.
  - Advances on step.
  - Range 0..SIDE_LAMPS-1 (dot mode) or 0..SIDE_LAMPS (fill mode), wrapping to 0.
- Dot mode: lamp index pos counted from the inner edge is lit.
- Fill mode: lamps 0..pos from the inner edge are lit; pos == SIDE_LAMPS means all off.
- Sweep complete = pos wraps to 0. COMF counts wraps; after COMFORT_SWEEPS wraps → IDLE.
- HAZ: phase bit set to 1 on entry and toggled on each step. All side and centre lamps equal the phase bit. brake is ignored.
- Brake (non-HAZ): centre group on. Any side group not sequencing is fully on.
- IDLE without brake: all lamps off.

## Timing
- Reset: FSM=IDLE, cnt=0, pos=0, phase=0, comfort count=0, leds=0, busy=0.
- leds and busy are registered: an input change is visible 1 clk later. An entry pattern (pos 0, or HAZ on) is visible 1 clk after the request is sampled.
- Each step lasts exactly TICK_DIV clks.
- Sweep period: SIDE_LAMPS steps (dot) or SIDE_LAMPS+1 steps (fill).
- Comfort duration: COMFORT_SWEEPS × period × TICK_DIV clks. busy drops on the clk after the final wrap.
- Async reset mid-sweep: all state cleared immediately. After release, the FSM resumes from IDLE, sampling inputs normally.
- Simultaneous comfort_l and comfort_r pulses: left wins.

## Test plan
- TICK_DIV=4, FILL_MODE=0, right_req held → leds cycles 0000000100, 0000000010, 0000000001 every 4 clks. First pattern appears 1 clk after the request.
- FILL_MODE=1, left_req held with brake → left group 001,011,111,000 (MSB outermost), repeating. Right group 111; centre 1111.
- hazard asserted mid left sweep → next clk leds=1111111111, then 0000000000 after 4 clks, alternating. Toggling brake has no effect.
- comfort_r pulse, SWEEPS=3, dot mode → 9 steps (36 clks) of right sweep, then leds=0, busy=0. A left_req during the run aborts it immediately.
- left_req and right_req together → HAZ pattern. Release both → leds=0 next clk.
- rst low mid-comfort → leds=0, busy=0 asynchronously. After release, nothing lights until a new request arrives.
